// File: rtl/ship_pkg.sv
// Shared types and constants for the ship movement logic.
// Column limits and controller state encoding.
package ship_pkg;

    typedef logic [4:0] col_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } ship_state_t;

    localparam col_t SHIP_X_MIN = 5'd0;
    localparam col_t SHIP_X_MAX = 5'd19;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable 5-bit down counter that saturates at 1.
// Used to pace auto-repeat steps in units of frame ticks.
module frame_down_counter
    import ship_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  col_t load_val,
    input  logic dec,
    output col_t cnt,
    output logic is_one
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt > 5'd1) begin
            cnt <= cnt - 5'd1;
        end
    end

    assign is_one = (cnt == 5'd1);

endmodule

// File: rtl/ship_move_ctrl.sv
// Turns held left/right buttons into single-step move requests
// with a typematic delay and auto-repeat, paced by frame ticks.
module ship_move_ctrl
    import ship_pkg::*;
#(
    parameter int REPEAT_DELAY = 12,
    parameter int REPEAT_RATE  = 4,
    parameter int X_MAX        = SHIP_X_MAX
)
(
    input  logic       clk_36MHz,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic       left_debounced,
    input  logic       right_debounced,
    input  logic [4:0] ship_x,
    output logic       step_left,
    output logic       step_right,
    output logic       busy
);

    localparam col_t DELAY_LD = 5'(REPEAT_DELAY);
    localparam col_t RATE_LD  = 5'(REPEAT_RATE);
    localparam col_t XMAX_C   = 5'(X_MAX);

    logic [1:0]  rst_sync;
    logic        rst_n;
    ship_state_t state;
    ship_state_t next_state;
    logic        dir;
    logic        next_dir;
    logic        eval;
    logic        req_l;
    logic        req_r;
    logic        req_match;
    logic        step_req;
    logic        cnt_load;
    col_t        cnt_val;
    logic        cnt_dec;
    col_t        cnt;
    logic        cnt_one;

    // Assert immediately, release on a clock edge.
    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    assign eval      = frame_tick & enable;
    assign req_l     = left_debounced & ~right_debounced;
    assign req_r     = right_debounced & ~left_debounced;
    assign req_match = dir ? req_r : req_l;

    always_comb begin
        next_state = state;
        next_dir   = dir;
        step_req   = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        if (eval) begin
            unique case (state)
                IDLE: begin
                    if (req_l || req_r) begin
                        step_req   = 1'b1;
                        next_dir   = req_r;
                        cnt_load   = 1'b1;
                        cnt_val    = DELAY_LD;
                        next_state = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!req_match) begin
                        next_state = IDLE;
                    end else if (cnt_one) begin
                        step_req   = 1'b1;
                        cnt_load   = 1'b1;
                        cnt_val    = RATE_LD;
                        next_state = REPEAT;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    frame_down_counter u_cnt (
        .clk      (clk_36MHz),
        .rst_n    (rst_n),
        .clr      (~enable),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .is_one   (cnt_one)
    );

    // Edge suppression gates only the pulse; pacing carries on.
    always_ff @(posedge clk_36MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dir        <= 1'b0;
            step_left  <= 1'b0;
            step_right <= 1'b0;
            busy       <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            step_left  <= 1'b0;
            step_right <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            dir        <= next_dir;
            step_left  <= step_req & ~next_dir & (ship_x != SHIP_X_MIN);
            step_right <= step_req & next_dir & (ship_x < XMAX_C);
            busy       <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_ship_move_ctrl.sv
// Directed bench for ship_move_ctrl: table of single ticks plus
// hand-written hold, reversal, boundary, enable and reset sequences.
module tb_ship_move_ctrl;

    logic       clk_36MHz = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       frame_tick = 1'b0;
    logic       left_debounced = 1'b0;
    logic       right_debounced = 1'b0;
    logic [4:0] ship_x = 5'd5;
    logic       step_left;
    logic       step_right;
    logic       busy;

    int checks = 0;
    int failures = 0;

    ship_move_ctrl dut (
        .clk_36MHz       (clk_36MHz),
        .reset           (reset),
        .enable          (enable),
        .frame_tick      (frame_tick),
        .left_debounced  (left_debounced),
        .right_debounced (right_debounced),
        .ship_x          (ship_x),
        .step_left       (step_left),
        .step_right      (step_right),
        .busy            (busy)
    );

    always #14 clk_36MHz = ~clk_36MHz;

    always @(negedge clk_36MHz) begin
        if (step_left && step_right) begin
            failures++;
            $display("FAIL both_steps: step_left=1 step_right=1 required not both");
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // One evaluated tick; returns outputs in the cycle after it.
    task automatic do_tick(input logic l, input logic r, input logic [4:0] x,
                           input logic en, output logic sl, output logic sr,
                           output logic bz);
        @(negedge clk_36MHz);
        left_debounced  = l;
        right_debounced = r;
        ship_x          = x;
        enable          = en;
        frame_tick      = 1'b1;
        @(negedge clk_36MHz);
        frame_tick = 1'b0;
        sl = step_left;
        sr = step_right;
        bz = busy;
        @(negedge clk_36MHz);
        chk("pulse_width", int'(step_left | step_right), 0);
        @(negedge clk_36MHz);
    endtask

    typedef struct {
        logic       l;
        logic       r;
        logic [4:0] x;
        logic       en;
        logic       sl;
        logic       sr;
        logic       bz;
    } vec_t;

    vec_t vecs[14];

    logic sl, sr, bz;
    int   pulses;
    int   bad;
    logic [31:0] mask;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 5'd18, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 5'd18, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 5'd18, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 5'd18, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 5'd18, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 5'd19, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 5'd19, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 5'd19, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk_36MHz);
        chk("rst_step_left", int'(step_left), 0);
        chk("rst_step_right", int'(step_right), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk_36MHz);

        for (int i = 0; i < 14; i++) begin
            do_tick(vecs[i].l, vecs[i].r, vecs[i].x, vecs[i].en, sl, sr, bz);
            chk($sformatf("vec%0d_step_left", i), int'(sl), int'(vecs[i].sl));
            chk($sformatf("vec%0d_step_right", i), int'(sr), int'(vecs[i].sr));
            chk($sformatf("vec%0d_busy", i), int'(bz), int'(vecs[i].bz));
        end

        // Long left hold: steps on ticks 1, 13, 17, 21, 25, 29.
        mask = '0;
        pulses = 0;
        bad = 0;
        for (int t = 1; t <= 30; t++) begin
            do_tick(1'b1, 1'b0, 5'd15, 1'b1, sl, sr, bz);
            if (sl) begin
                mask[t] = 1'b1;
                pulses++;
            end
            if (sr || !bz) bad++;
        end
        chk("hold_left_mask", int'(mask), int'(32'h2222_2002));
        chk("hold_left_pulses", pulses, 6);
        chk("hold_left_busy", bad, 0);
        do_tick(1'b0, 1'b0, 5'd15, 1'b1, sl, sr, bz);
        chk("hold_left_release_busy", int'(bz), 0);

        // Both buttons cancel, then left alone steps.
        pulses = 0;
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            do_tick(1'b1, 1'b1, 5'd10, 1'b1, sl, sr, bz);
            if (sl || sr) pulses++;
            if (bz) bad++;
        end
        chk("both_pulses", pulses, 0);
        chk("both_busy", bad, 0);
        do_tick(1'b1, 1'b0, 5'd10, 1'b1, sl, sr, bz);
        chk("both_release_right_step", int'(sl), 1);
        do_tick(1'b0, 1'b0, 5'd10, 1'b1, sl, sr, bz);

        // Right edge: no pulses while held, still busy.
        pulses = 0;
        for (int t = 0; t < 20; t++) begin
            do_tick(1'b0, 1'b1, 5'd19, 1'b1, sl, sr, bz);
            if (sl || sr) pulses++;
        end
        chk("right_edge_pulses", pulses, 0);
        chk("right_edge_busy", int'(bz), 1);
        do_tick(1'b0, 1'b0, 5'd19, 1'b1, sl, sr, bz);

        // Reversal while in REPEAT.
        for (int t = 0; t < 14; t++) begin
            do_tick(1'b1, 1'b0, 5'd15, 1'b1, sl, sr, bz);
        end
        do_tick(1'b0, 1'b1, 5'd15, 1'b1, sl, sr, bz);
        chk("rev_tick_step", int'(sl | sr), 0);
        chk("rev_tick_busy", int'(bz), 0);
        do_tick(1'b0, 1'b1, 5'd15, 1'b1, sl, sr, bz);
        chk("rev_next_step_right", int'(sr), 1);
        pulses = 0;
        for (int t = 0; t < 11; t++) begin
            do_tick(1'b0, 1'b1, 5'd15, 1'b1, sl, sr, bz);
            if (sl || sr) pulses++;
        end
        chk("rev_delay_quiet", pulses, 0);
        do_tick(1'b0, 1'b1, 5'd15, 1'b1, sl, sr, bz);
        chk("rev_delay_step_right", int'(sr), 1);
        do_tick(1'b0, 1'b0, 5'd15, 1'b1, sl, sr, bz);

        // Enable dropped mid-DELAY.
        for (int t = 0; t < 3; t++) begin
            do_tick(1'b0, 1'b1, 5'd5, 1'b1, sl, sr, bz);
        end
        @(negedge clk_36MHz);
        enable = 1'b0;
        repeat (2) @(negedge clk_36MHz);
        chk("en_off_busy", int'(busy), 0);
        chk("en_off_steps", int'(step_left | step_right), 0);
        do_tick(1'b0, 1'b1, 5'd5, 1'b1, sl, sr, bz);
        chk("en_restore_step_right", int'(sr), 1);
        chk("en_restore_busy", int'(bz), 1);

        // Reset asserted mid-DELAY.
        do_tick(1'b0, 1'b1, 5'd5, 1'b1, sl, sr, bz);
        @(negedge clk_36MHz);
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        repeat (3) @(negedge clk_36MHz);
        reset = 1'b1;
        repeat (4) @(negedge clk_36MHz);
        chk("rst_release_steps", int'(step_left | step_right), 0);
        chk("rst_release_busy", int'(busy), 0);
        do_tick(1'b0, 1'b1, 5'd5, 1'b1, sl, sr, bz);
        chk("rst_restore_step_right", int'(sr), 1);
        chk("rst_restore_busy", int'(bz), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
